sim_jtag_multi_engine: RTL
==========================

// Module: sim_jtag_multi_engine
// PURPOSE
//  Parametrised, synthesisable successor to the DPI JTAG tick driver. Drives NUM_CH independent JTAG
//  ports from per-channel command FIFOs, one TCK period per command, paced by a shared runtime tick divider.
//  Optional per-command TDO capture is returned on a valid/ready response channel.
//  Sits between a host/bench command source (or AXI-to-cmd bridge) and the DUT TAP(s) in debug-module benches.
// PARAMETERS
//  NUM_CH      2   number of independent JTAG ports (>=1)
//  DEPTH       4   command FIFO entries per channel (power of 2, >=2)
//  TICK_DELAY  50  reset value of the tick counter (cycles before the first tick)
//  TDO_FILL    0   TDO value returned when the target does not drive TDO (deterministic; no random fill)
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          synchronous active-low reset
//  enable_i       in   1          1: tick counter runs; 0: counter and all channel FSMs frozen
//  div_i          in   16         tick period minus 1; sampled on each counter reload
//  cmd_valid_i    in   NUM_CH     per-channel command valid
//  cmd_ready_o    out  NUM_CH     per-channel FIFO not full
//  cmd_data_i     in   4*NUM_CH   per channel {cap, trst_n, tms, tdi}; channel c at [4c+3:4c]
//  rsp_valid_o    out  NUM_CH     captured TDO available
//  rsp_ready_i    in   NUM_CH     response consumed
//  rsp_tdo_o      out  NUM_CH     captured TDO bit
//  jtag_tck_o     out  NUM_CH     TCK
//  jtag_tms_o     out  NUM_CH     TMS
//  jtag_tdi_o     out  NUM_CH     TDI
//  jtag_trst_no   out  NUM_CH     TRSTn
//  jtag_tdo_i     in   NUM_CH     TDO data from target
//  jtag_tdo_oe_i  in   NUM_CH     TDO driven by target
//  busy_o         out  NUM_CH     channel FSM not IDLE or FIFO not empty
// BEHAVIOUR
//  - Reset (rst_ni=0 at posedge): tck=0, tms=1, tdi=0, trst_n=0, rsp_valid=0, rsp_tdo=0, busy=0,
//    FIFOs emptied, counter=TICK_DELAY, FSMs to IDLE. Applies mid-operation, mid-period included.
//  - Tick: while enable_i, counter decrements; at 0 a one-cycle tick fires and counter reloads div_i.
//    div_i=0 gives a tick every cycle. TCK period = 2*(div_i+1) cycles.
//  - FIFO push on cmd_valid&cmd_ready; pushes accepted while enable_i=0. Push+pop in same cycle when full:
//    pop frees the slot only next cycle (cmd_ready stays 0).
//  - Per-channel FSM advances on tick only. All JTAG outputs registered (visible the cycle after the tick).
//      IDLE: tck=0. On tick with FIFO non-empty: pop, load tms/tdi/trst_n, -> LOW.
//      LOW:  tck=0. On tick -> HIGH, tck=1. If cap=1, sample tdo_eff = oe ? tdo : TDO_FILL
//            into rsp_tdo and set rsp_valid. If cap=1 while rsp_valid=1 and not (rsp_valid&rsp_ready)
//            in that cycle: stall in LOW (tck held 0) and retry on later ticks.
//      HIGH: tck=1. On tick: FIFO non-empty -> pop next, LOW (back-to-back, no gap); else -> IDLE, tck=0.
//  - tms/tdi/trst_n hold last command values in IDLE.
//  - rsp_valid stays set until rsp_ready; ready and a new capture in the same cycle count as slot free.
//  - Channels are fully independent apart from the shared tick.
//  - 16-bit counter; no overflow: reload always from div_i.
// CONFIGURATION
//  JTAG_TAP_RESET_EN defined:
//    - After reset, every channel enters TAPRST before IDLE.
//    - TAPRST runs 5 TCK periods with tms=1, tdi=0. trst_n=0 in period 1, 1 in periods 2-5.
//    - busy_o=1 throughout; FIFO accepts pushes but is not popped until TAPRST completes.
//  Not defined: no TAPRST state. Channels start in IDLE. trst_n stays 0 until the first command.
// TESTING
//  1. NUM_CH=2, div=0, ch0 cmd {1,1,0,1}, tdo=1, oe=1:
//     ch0 tck 0 then 1 one cycle apart; tdi=1, tms=0; rsp_valid with rsp_tdo=1 the cycle tck rises; ch1 idle.
//  2. ch0 cap cmd, oe=0, tdo=1, TDO_FILL=0 -> rsp_tdo=0.
//  3. div=3, 3 cmds: tck 4 cycles low / 4 high per cmd, 24 cycles, no gap; IDLE after.
//  4. enable=0, push 5 cmds DEPTH=4: cmd_ready=0 after 4th, 5th not taken;
//     enable=1 -> exactly 4 TCK pulses.
//  5. rsp_ready=0, two cap cmds: 2nd held in LOW (tck=0) until rsp_ready pulse, then tck rises next tick,
//     rsp_tdo updated.
//  6. rst_ni=0 one cycle while tck=1, 2 entries queued -> next cycle tck=0, tms=1, trst_n=0,
//     busy=0, cmd_ready=1; with JTAG_TAP_RESET_EN: 5 pulses tms=1 then queued cmds run.

Source files
------------

// File: rtl/sim_jtag_multi_engine_if.sv
// Command/response handshake bundle for sim_jtag_multi_engine; one lane per JTAG channel,
// channel c of cmd_data at [4c+3:4c] as {cap, trst_n, tms, tdi}.
interface sim_jtag_multi_engine_if #(
   parameter int unsigned NUM_CH = 2
);
   logic [NUM_CH-1:0]   cmd_valid;
   logic [NUM_CH-1:0]   cmd_ready;
   logic [4*NUM_CH-1:0] cmd_data;
   logic [NUM_CH-1:0]   rsp_valid;
   logic [NUM_CH-1:0]   rsp_ready;
   logic [NUM_CH-1:0]   rsp_tdo;

   modport master (
      output cmd_valid, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_tdo
   );
   modport slave (
      input  cmd_valid, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_tdo
   );
endinterface

// File: rtl/sim_jtag_multi_engine.sv
// NUM_CH independent JTAG drivers fed from per-channel command FIFOs, one TCK period per command,
// paced by a shared tick divider. Optional post-reset TAP reset sequence: define JTAG_TAP_RESET_EN.
module sim_jtag_multi_engine #(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned DEPTH      = 4,
   parameter logic [15:0] TICK_DELAY = 16'd50,
   parameter logic        TDO_FILL   = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,
   input  logic [15:0]           div_i,
   sim_jtag_multi_engine_if.slave bus,
   output logic [NUM_CH-1:0]     jtag_tck_o,
   output logic [NUM_CH-1:0]     jtag_tms_o,
   output logic [NUM_CH-1:0]     jtag_tdi_o,
   output logic [NUM_CH-1:0]     jtag_trst_no,
   input  logic [NUM_CH-1:0]     jtag_tdo_i,
   input  logic [NUM_CH-1:0]     jtag_tdo_oe_i,
   output logic [NUM_CH-1:0]     busy_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_TAPRST} state_e;

`ifdef JTAG_TAP_RESET_EN
   localparam state_e RST_STATE = S_TAPRST;
`else
   localparam state_e RST_STATE = S_IDLE;
`endif

   logic [15:0] tick_cnt_q, tick_cnt_d;
   logic        tick;

   always_comb begin
      tick       = enable_i && (tick_cnt_q == '0);
      tick_cnt_d = tick_cnt_q;
      if (enable_i) tick_cnt_d = tick ? div_i : tick_cnt_q - 16'd1;
   end

   // NOTE: sequential state is always written with <=, so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) tick_cnt_q <= TICK_DELAY;
      else         tick_cnt_q <= tick_cnt_d;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [3:0]    mem_q [DEPTH];
      logic [AW-1:0] wptr_q, rptr_q;
      logic [CW-1:0] fcnt_q, fcnt_d;
      logic          push, pop, empty, full, stall, tdo_eff;
      logic [3:0]    head;
      state_e        state_q, state_d;
      logic          tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, trst_q, trst_d;
      logic          cap_q, cap_d, rv_q, rv_d, rt_q, rt_d;
`ifdef JTAG_TAP_RESET_EN
      logic [2:0]    tap_cnt_q, tap_cnt_d;
      logic          tap_done;
      assign tap_done = tck_q && (tap_cnt_q == 3'd4);
`endif

      assign full    = (fcnt_q == FULL_CNT);
      assign empty   = (fcnt_q == '0);
      assign push    = bus.cmd_valid[c] & ~full;
      assign head    = mem_q[rptr_q];
      assign stall   = cap_q & rv_q & ~bus.rsp_ready[c];
      assign tdo_eff = jtag_tdo_oe_i[c] ? jtag_tdo_i[c] : TDO_FILL;

      always_comb begin
         fcnt_d = fcnt_q;
         if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
         else if (pop && !push) fcnt_d = fcnt_q - 1'b1;
      end

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
         end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            fcnt_q <= fcnt_d;
         end
      end

      // NOTE: FIFO storage has no reset; entries are only read after being written.
      always_ff @(posedge clk_i) begin
         if (push) mem_q[wptr_q] <= bus.cmd_data[4*c +: 4];
      end

      always_ff @(posedge clk_i) begin
         if (!rst_ni) state_q <= RST_STATE;
         else         state_q <= state_d;
      end

      // NOTE: every comb output gets a default first so no path can infer a latch.
      always_comb begin
         state_d = state_q;
         pop     = 1'b0;
         if (tick) begin
            unique case (state_q)
               S_IDLE: if (!empty) begin
                  pop     = 1'b1;
                  state_d = S_LOW;
               end
               S_LOW: if (!stall) state_d = S_HIGH;
               S_HIGH: begin
                  pop     = !empty;
                  state_d = empty ? S_IDLE : S_LOW;
               end
`ifdef JTAG_TAP_RESET_EN
               S_TAPRST: if (tap_done) state_d = S_IDLE;
`endif
               default: state_d = S_IDLE;
            endcase
         end
      end

      always_comb begin
         tck_d  = tck_q;
         tms_d  = tms_q;
         tdi_d  = tdi_q;
         trst_d = trst_q;
         cap_d  = cap_q;
         rv_d   = rv_q & ~bus.rsp_ready[c];
         rt_d   = rt_q;
`ifdef JTAG_TAP_RESET_EN
         tap_cnt_d = tap_cnt_q;
`endif
         if (pop) {cap_d, trst_d, tms_d, tdi_d} = head;
         if (tick) begin
            unique case (state_q)
               S_LOW: if (!stall) begin
                  tck_d = 1'b1;
                  if (cap_q) begin
                     rv_d = 1'b1;
                     rt_d = tdo_eff;
                  end
               end
               S_HIGH: tck_d = 1'b0;
`ifdef JTAG_TAP_RESET_EN
               S_TAPRST: begin
                  // trst_n is released at the falling edge that ends the first period.
                  tms_d = 1'b1;
                  tdi_d = 1'b0;
                  tck_d = ~tck_q;
                  if (tck_q) begin
                     trst_d    = 1'b1;
                     tap_cnt_d = tap_cnt_q + 3'd1;
                  end
               end
`endif
               default: ;
            endcase
         end
      end

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            tck_q  <= 1'b0;
            tms_q  <= 1'b1;
            tdi_q  <= 1'b0;
            trst_q <= 1'b0;
            cap_q  <= 1'b0;
            rv_q   <= 1'b0;
            rt_q   <= 1'b0;
`ifdef JTAG_TAP_RESET_EN
            tap_cnt_q <= 3'd0;
`endif
         end else begin
            tck_q  <= tck_d;
            tms_q  <= tms_d;
            tdi_q  <= tdi_d;
            trst_q <= trst_d;
            cap_q  <= cap_d;
            rv_q   <= rv_d;
            rt_q   <= rt_d;
`ifdef JTAG_TAP_RESET_EN
            tap_cnt_q <= tap_cnt_d;
`endif
         end
      end

      assign bus.cmd_ready[c] = ~full;
      assign bus.rsp_valid[c] = rv_q;
      assign bus.rsp_tdo[c]   = rt_q;
      assign jtag_tck_o[c]    = tck_q;
      assign jtag_tms_o[c]    = tms_q;
      assign jtag_tdi_o[c]    = tdi_q;
      assign jtag_trst_no[c]  = trst_q;
      assign busy_o[c]        = (state_q != S_IDLE) | ~empty;
   end
endmodule
